phv_writeback: RTL and testbench

- Downstream neighbour of the stateless ALU atom: merges the ALU's 32-bit result into a selected field of the packet header vector (PHV) and registers the updated PHV toward the next match-action stage.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so that `in_ready` never depends combinationally on `out_ready`.
- Single clock domain.

---
 rtl/phv_writeback.sv | 122 ++++++++++++
 tb/tb_phv_writeback.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phv_writeback.sv
// PHV writeback stage: merges the ALU result into one PHV field and forwards the PHV through a 2-entry skid buffer.
// Optional PHV_WB_STATS_EN adds pkt_cnt / wr_cnt statistics outputs.
module phv_writeback #(
    parameter int COUNT_WIDTH = 32,
    parameter int NUM_FIELDS  = 8,
    parameter int SEL_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_FIELDS*COUNT_WIDTH-1:0] in_phv,
    input  logic [COUNT_WIDTH-1:0]            in_result,
    input  logic                              in_wr_en,
    input  logic [SEL_WIDTH-1:0]              in_dst_sel,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_FIELDS*COUNT_WIDTH-1:0] out_phv,
    output logic                              err_sel
`ifdef PHV_WB_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0]            pkt_cnt,
    output logic [COUNT_WIDTH-1:0]            wr_cnt
`endif
);

    localparam int PHV_WIDTH = NUM_FIELDS * COUNT_WIDTH;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                 state_reg;
    logic [PHV_WIDTH-1:0]   main_reg;
    logic [PHV_WIDTH-1:0]   skid_reg;
    logic                   err_reg;
    logic [PHV_WIDTH-1:0]   merged;
    logic                   accept;
    logic                   deliver;
    logic                   sel_oob;
    logic                   wr_legal;

    // Handshake flags come straight from the state register, so in_ready never sees out_ready.
    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    // One extra bit so NUM_FIELDS == 2**SEL_WIDTH still compares correctly.
    assign sel_oob  = ({1'b0, in_dst_sel} >= (SEL_WIDTH + 1)'(NUM_FIELDS));
    assign wr_legal = in_wr_en & ~sel_oob;

    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            assign merged[gi*COUNT_WIDTH +: COUNT_WIDTH] =
                (wr_legal && (in_dst_sel == SEL_WIDTH'(gi))) ? in_result
                                                             : in_phv[gi*COUNT_WIDTH +: COUNT_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (accept && in_wr_en && sel_oob) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_reg  <= merged;
                        state_reg <= ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_reg <= merged;
                    end else if (accept) begin
                        skid_reg  <= merged;
                        state_reg <= FULL;
                    end else if (deliver) begin
                        state_reg <= EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        main_reg  <= skid_reg;
                        state_reg <= ONE;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

    assign out_phv = main_reg;
    assign err_sel = err_reg;

`ifdef PHV_WB_STATS_EN
    logic [COUNT_WIDTH-1:0] pkt_cnt_reg;
    logic [COUNT_WIDTH-1:0] wr_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_reg <= '0;
            wr_cnt_reg  <= '0;
        end else begin
            if (deliver) begin
                pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
            end
            if (accept && wr_legal) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
        end
    end

    assign pkt_cnt = pkt_cnt_reg;
    assign wr_cnt  = wr_cnt_reg;
`endif

endmodule

// File: tb/tb_phv_writeback.sv
// Self-checking bench for phv_writeback: FIFO-level reference model checked every cycle plus directed literal checks.
module tb_phv_writeback;
    localparam int W  = 32;
    localparam int NF = 8;
    localparam int SW = 4;
    localparam int PW = NF * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_phv = '0;
    logic [W-1:0]  in_result = '0;
    logic          in_wr_en = 1'b0;
    logic [SW-1:0] in_dst_sel = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_phv;
    logic          err_sel;
`ifdef PHV_WB_STATS_EN
    logic [W-1:0]  pkt_cnt;
    logic [W-1:0]  wr_cnt;
`endif

    phv_writeback #(.COUNT_WIDTH(W), .NUM_FIELDS(NF), .SEL_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_phv(in_phv),
        .in_result(in_result), .in_wr_en(in_wr_en), .in_dst_sel(in_dst_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_phv(out_phv),
        .err_sel(err_sel)
`ifdef PHV_WB_STATS_EN
        , .pkt_cnt(pkt_cnt), .wr_cnt(wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] model_merge(input logic [PW-1:0] p, input logic [W-1:0] r,
                                                  input logic w, input logic [SW-1:0] s);
        logic [PW-1:0] m;
        m = p;
        if (w && int'(s) < NF) m[int'(s)*W +: W] = r;
        return m;
    endfunction

    function automatic logic [PW-1:0] mk(input int tag);
        logic [PW-1:0] m;
        for (int k = 0; k < NF; k++) m[k*W +: W] = W'(tag * 256 + k);
        return m;
    endfunction

    // Reference model: an ordered queue of at most two beats.
    logic [PW-1:0] mq[$];
    logic [PW-1:0] log_q[$];
    logic [PW-1:0] last_m = '0;
    logic          err_m = 1'b0;
    int unsigned   pkt_m = 0;
    int unsigned   wr_m = 0;
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_phv = '0;

    always @(negedge clk) begin
        logic          ev, er, dlv, acc;
        logic [PW-1:0] ep;
        if (!rst_n) begin
            mq.delete();
            last_m = '0; err_m = 1'b0; pkt_m = 0; wr_m = 0; prev_stall = 1'b0;
            chk("rst_out_valid", out_valid, 1'b0);
        end else begin
            ev = (mq.size() > 0);
            er = (mq.size() < 2);
            ep = ev ? mq[0] : last_m;
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, er);
            chk("out_phv", out_phv, ep);
            chk("err_sel", err_sel, err_m);
            if (prev_stall) chk("stall_stable", out_phv, prev_phv);
`ifdef PHV_WB_STATS_EN
            chk("pkt_cnt", pkt_cnt, W'(pkt_m));
            chk("wr_cnt", wr_cnt, W'(wr_m));
`endif
            dlv = ev && out_ready;
            acc = in_valid && er;
            prev_stall = ev && !out_ready;
            prev_phv   = out_phv;
            if (dlv) begin
                log_q.push_back(mq[0]);
                last_m = mq[0];
                void'(mq.pop_front());
                pkt_m++;
            end
            if (acc) begin
                mq.push_back(model_merge(in_phv, in_result, in_wr_en, in_dst_sel));
                if (in_wr_en && int'(in_dst_sel) >= NF) err_m = 1'b1;
                if (in_wr_en && int'(in_dst_sel) < NF) wr_m++;
            end
        end
    end

    task automatic send(input logic [PW-1:0] p, input logic [W-1:0] r, input logic w, input logic [SW-1:0] s);
        bit done;
        done = 0;
        in_phv = p; in_result = r; in_wr_en = w; in_dst_sel = s; in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", done, 1'b1);
    endtask

    initial begin
        logic [PW-1:0] base, a, b, c, x, y;
        logic [PW-1:0] exp_abc[3];
        int acc, legal, cyc;
        bit hs;

        base = mk(0);
        for (int k = 0; k < NF; k++) base[k*W +: W] = W'(32'h10 + k);

        // Reset state
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_phv", out_phv, '0);
        chk("reset_err", err_sel, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Write field 3
        send(base, 32'hDEAD, 1'b1, 4'd3);
        @(negedge clk);
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_f3", out_phv[3*W +: W], 32'hDEAD);
        chk("t1_f0", out_phv[0 +: W], 32'h10);
        chk("t1_f7", out_phv[7*W +: W], 32'h17);
        chk("t1_err", err_sel, 1'b0);
        @(posedge clk); #1;

        // Pass-through
        send(base, 32'hFFFF, 1'b0, 4'd5);
        @(negedge clk);
        chk("t2_phv", out_phv, base);
        @(posedge clk); #1;

        // Out-of-range selector, then a legal write
        send(base, 32'hBEEF, 1'b1, 4'd9);
        @(negedge clk);
        chk("t3_phv", out_phv, base);
        chk("t3_err", err_sel, 1'b1);
        @(posedge clk); #1;
        send(base, 32'h1234, 1'b1, 4'd2);
        @(negedge clk);
        chk("t3_err_sticky", err_sel, 1'b1);
        chk("t3_f2", out_phv[2*W +: W], 32'h1234);
        repeat (2) @(posedge clk); #1;

        // Back-pressure: A, B, C
        a = mk(1); b = mk(2); c = mk(3);
        exp_abc[0] = a; exp_abc[1] = b; exp_abc[2] = c;
        out_ready = 1'b0;
        log_q.delete();
        send(a, 32'h0, 1'b0, 4'd0);
        send(b, 32'h0, 1'b0, 4'd0);
        in_phv = c; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abc_in_ready_low", in_ready, 1'b0);
            chk("abc_hold_a", out_phv, a);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(c, 32'h0, 1'b0, 4'd0);
        repeat (4) @(posedge clk); #1;
        chk("abc_count", log_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("abc_order%0d", i), (log_q.size() > i) ? log_q[i] : '0, exp_abc[i]);

        // Random traffic from a fresh reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        log_q.delete();
        acc = 0; legal = 0; cyc = 0;
        while (acc < 100 && cyc < 5000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                for (int k = 0; k < NF; k++) in_phv[k*W +: W] = $urandom;
                in_result  = $urandom;
                in_wr_en   = 1'($urandom_range(0, 1));
                in_dst_sel = 4'($urandom_range(0, 15));
                in_valid   = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = in_valid && in_ready;
            if (hs) begin
                acc++;
                if (in_wr_en && int'(in_dst_sel) < NF) legal++;
            end
            @(posedge clk); #1;
            if (hs) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("rand_accepted", acc, 100);
        chk("rand_delivered", log_q.size(), 100);
`ifdef PHV_WB_STATS_EN
        chk("rand_pkt_cnt", pkt_cnt, 32'd100);
        chk("rand_wr_cnt", wr_cnt, W'(legal));
`endif

        // Reset while FULL
        x = mk(4); y = mk(5);
        out_ready = 1'b0;
        send(x, 32'h0, 1'b0, 4'd0);
        send(y, 32'h0, 1'b0, 4'd0);
        log_q.delete();
        #2 rst_n = 1'b0;
        #1 chk("rstfull_async_valid", out_valid, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("rstfull_no_emit", log_q.size(), 0);
        chk("rstfull_out_valid", out_valid, 1'b0);
        chk("rstfull_in_ready", in_ready, 1'b1);
        chk("rstfull_out_phv", out_phv, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
